// File: rtl/rs_bank.sv
// rs_bank: reservation-station bank that snoops NUM_CDB result buses and issues one ready entry per cycle.
// Define RS_AGE_ORDER_EN for oldest-first select via an age matrix; otherwise the lowest-index ready entry wins.
// Packed layouts (LSB first):
//   alloc_data : Q_j, Q_k, V_j, V_k, ROB_entry, ALU_op[3:0], branch_type[2:0], load
//   CDB_in[c]  : dest_ROB_entry, result, load_step1
//   issue_data : rs1, rs2, ROB_entry, ALU_op, branch_type, load, valid_operands
module rs_bank #(
  parameter int NUM_ENTRIES = 4,
  parameter int NUM_CDB = 1,
  parameter int XLEN = 32,
  parameter int ROB_W = 5,
  localparam int RS_W = 3*ROB_W + 2*XLEN + 8,
  localparam int CDB_W = ROB_W + XLEN + 1,
  localparam int OUT_W = 2*XLEN + ROB_W + 9,
  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mispredicted,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [RS_W-1:0]          alloc_data,
  input  logic [NUM_CDB*CDB_W-1:0] CDB_in,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OUT_W-1:0]         issue_data,
  output logic [CNT_W-1:0]         free_count
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] v_q, v_d, ld_q, ld_d;
  logic [ROB_W-1:0]       qj_q [NUM_ENTRIES];
  logic [ROB_W-1:0]       qj_d [NUM_ENTRIES];
  logic [ROB_W-1:0]       qk_q [NUM_ENTRIES];
  logic [ROB_W-1:0]       qk_d [NUM_ENTRIES];
  logic [XLEN-1:0]        vj_q [NUM_ENTRIES];
  logic [XLEN-1:0]        vj_d [NUM_ENTRIES];
  logic [XLEN-1:0]        vk_q [NUM_ENTRIES];
  logic [XLEN-1:0]        vk_d [NUM_ENTRIES];
  logic [ROB_W-1:0]       rob_q [NUM_ENTRIES];
  logic [ROB_W-1:0]       rob_d [NUM_ENTRIES];
  logic [3:0]             op_q [NUM_ENTRIES];
  logic [3:0]             op_d [NUM_ENTRIES];
  logic [2:0]             br_q [NUM_ENTRIES];
  logic [2:0]             br_d [NUM_ENTRIES];

  logic [ROB_W-1:0] a_qj, a_qk, a_rob;
  logic [XLEN-1:0]  a_vj, a_vk;
  logic [3:0]       a_op;
  logic [2:0]       a_br;
  logic             a_ld;

  assign a_qj  = alloc_data[0 +: ROB_W];
  assign a_qk  = alloc_data[ROB_W +: ROB_W];
  assign a_vj  = alloc_data[2*ROB_W +: XLEN];
  assign a_vk  = alloc_data[2*ROB_W+XLEN +: XLEN];
  assign a_rob = alloc_data[2*ROB_W+2*XLEN +: ROB_W];
  assign a_op  = alloc_data[3*ROB_W+2*XLEN +: 4];
  assign a_br  = alloc_data[3*ROB_W+2*XLEN+4 +: 3];
  assign a_ld  = alloc_data[RS_W-1];

  // Returns {hit, result}; descending scan so the lowest matching port overrides.
  function automatic logic [XLEN:0] snoop(input logic [ROB_W-1:0] tag,
                                          input logic [NUM_CDB*CDB_W-1:0] cdb);
    logic [XLEN:0] r;
    r = '0;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (tag != '0 && cdb[c*CDB_W +: ROB_W] == tag && !cdb[c*CDB_W+CDB_W-1])
        r = {1'b1, cdb[c*CDB_W+ROB_W +: XLEN]};
    end
    return r;
  endfunction

  logic [XLEN:0] wj [NUM_ENTRIES];
  logic [XLEN:0] wk [NUM_ENTRIES];
  logic [XLEN:0] bj, bk;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wj[i] = snoop(qj_q[i], CDB_in);
      wk[i] = snoop(qk_q[i], CDB_in);
    end
  end
  assign bj = snoop(a_qj, CDB_in);
  assign bk = snoop(a_qk, CDB_in);

  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             any_free, sel_found, alloc_fire, issue_fire;
  logic [CNT_W-1:0] cnt;
  logic [NUM_ENTRIES-1:0] ready, cand;

  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    cnt = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (!v_q[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
        cnt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      ready[i] = v_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
  end

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] = 1: entry i was allocated before entry j.
  logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_ready;

  always_ff @(posedge clk) begin
    if (reset || mispredicted) begin
      for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= '0;
    end else if (alloc_fire) begin
      age_q[free_idx] <= '0;
      for (int j = 0; j < NUM_ENTRIES; j++) age_q[j][free_idx] <= v_q[j];
    end
  end

  always_comb begin
    older_ready = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      for (int j = 0; j < NUM_ENTRIES; j++)
        if (ready[j] && age_q[j][i]) older_ready[i] = 1'b1;
  end
  assign cand = ready & ~older_ready;
`else
  assign cand = ready;
`endif

  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_found = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_ready = any_free;
  assign free_count  = cnt;
  assign issue_valid = sel_found;
  assign alloc_fire  = alloc_valid && any_free;
  assign issue_fire  = sel_found && issue_ready;

  always_comb begin
    issue_data = '0;
    if (sel_found)
      issue_data = {1'b1, ld_q[sel_idx], br_q[sel_idx], op_q[sel_idx], rob_q[sel_idx],
                    vk_q[sel_idx], vj_q[sel_idx]};
  end

  // Wakeup only touches occupied entries; the allocated entry is resolved by the bypass instead.
  always_comb begin
    v_d = v_q;  ld_d = ld_q;
    qj_d = qj_q; qk_d = qk_q; vj_d = vj_q; vk_d = vk_q;
    rob_d = rob_q; op_d = op_q; br_d = br_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (v_q[i]) begin
        if (wj[i][XLEN]) begin qj_d[i] = '0; vj_d[i] = wj[i][XLEN-1:0]; end
        if (wk[i][XLEN]) begin qk_d[i] = '0; vk_d[i] = wk[i][XLEN-1:0]; end
      end
    end
    if (issue_fire) v_d[sel_idx] = 1'b0;
    if (alloc_fire) begin
      v_d[free_idx]   = 1'b1;
      qj_d[free_idx]  = bj[XLEN] ? '0 : a_qj;
      vj_d[free_idx]  = bj[XLEN] ? bj[XLEN-1:0] : a_vj;
      qk_d[free_idx]  = bk[XLEN] ? '0 : a_qk;
      vk_d[free_idx]  = bk[XLEN] ? bk[XLEN-1:0] : a_vk;
      rob_d[free_idx] = a_rob;
      op_d[free_idx]  = a_op;
      br_d[free_idx]  = a_br;
      ld_d[free_idx]  = a_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || mispredicted) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        qj_q[i] <= '0; qk_q[i] <= '0; vj_q[i] <= '0; vk_q[i] <= '0;
        rob_q[i] <= '0; op_q[i] <= '0; br_q[i] <= '0;
      end
    end else begin
      v_q  <= v_d;
      ld_q <= ld_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        qj_q[i] <= qj_d[i]; qk_q[i] <= qk_d[i]; vj_q[i] <= vj_d[i]; vk_q[i] <= vk_d[i];
        rob_q[i] <= rob_d[i]; op_q[i] <= op_d[i]; br_q[i] <= br_d[i];
      end
    end
  end
endmodule

// File: tb/tb_rs_bank.sv
// Bench for rs_bank: directed scenarios plus a randomized run against a sequence-numbered
// reference model of the bank (oldest-by-allocation or lowest-index select, per RS_AGE_ORDER_EN).
module tb_rs_bank;
  localparam int N = 4;
  localparam int NC = 2;
  localparam int XLEN = 32;
  localparam int ROB_W = 5;
  localparam int RS_W = 3*ROB_W + 2*XLEN + 8;
  localparam int CDB_W = ROB_W + XLEN + 1;
  localparam int OUT_W = 2*XLEN + ROB_W + 9;
  localparam int CNT_W = $clog2(N) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, mispredicted, alloc_valid, issue_ready;
  logic [RS_W-1:0]     alloc_data;
  logic [NC*CDB_W-1:0] CDB_in;
  logic                alloc_ready, issue_valid;
  logic [OUT_W-1:0]    issue_data;
  logic [CNT_W-1:0]    free_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [ROB_W-1:0] exp_q[$];

  rs_bank #(.NUM_ENTRIES(N), .NUM_CDB(NC), .XLEN(XLEN), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset), .mispredicted(mispredicted),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_data(alloc_data),
    .CDB_in(CDB_in), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_data(issue_data), .free_count(free_count)
  );

  // ---------------- reference model ----------------
  logic             m_v   [N];
  logic [ROB_W-1:0] m_qj  [N];
  logic [ROB_W-1:0] m_qk  [N];
  logic [XLEN-1:0]  m_vj  [N];
  logic [XLEN-1:0]  m_vk  [N];
  logic [ROB_W-1:0] m_rob [N];
  logic [3:0]       m_op  [N];
  logic [2:0]       m_br  [N];
  logic             m_ld  [N];
  int               m_seq [N];
  int               seq_ctr = 0;

  function automatic logic [RS_W-1:0] mk_rs(input logic [ROB_W-1:0] qj, input logic [ROB_W-1:0] qk,
                                            input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                                            input logic [ROB_W-1:0] rob);
    return {rob[0], rob[2:0], rob[3:0] ^ 4'h5, rob, vk, vj, qk, qj};
  endfunction

  function automatic logic [OUT_W-1:0] mk_out(input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                              input logic [ROB_W-1:0] rob);
    return {1'b1, rob[0], rob[2:0], rob[3:0] ^ 4'h5, rob, rs2, rs1};
  endfunction

  function automatic logic [CDB_W-1:0] mk_cdb(input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] res,
                                              input logic ls1);
    return {ls1, res, tag};
  endfunction

  // First port (lowest c) carrying a usable result for tag; tag 0 never matches.
  function automatic logic [XLEN:0] m_snoop(input logic [ROB_W-1:0] tag);
    logic [CDB_W-1:0] p;
    if (tag == '0) return '0;
    for (int c = 0; c < NC; c++) begin
      p = CDB_in[c*CDB_W +: CDB_W];
      if (p[ROB_W-1:0] == tag && !p[CDB_W-1]) return {1'b1, p[ROB_W +: XLEN]};
    end
    return '0;
  endfunction

  function automatic int m_sel();
    int s = -1;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && m_qj[i] == '0 && m_qk[i] == '0) begin
`ifdef RS_AGE_ORDER_EN
        if (s < 0 || m_seq[i] < m_seq[s]) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  function automatic int m_free();
    int f = 0;
    for (int i = 0; i < N; i++) if (!m_v[i]) f++;
    return f;
  endfunction

  function automatic logic [OUT_W-1:0] m_out();
    int s = m_sel();
    if (s < 0) return '0;
    return {1'b1, m_ld[s], m_br[s], m_op[s], m_rob[s], m_vk[s], m_vj[s]};
  endfunction

  task automatic m_clock();
    int s, f;
    logic [XLEN:0] h;
    logic [RS_W-1:0] a;
    s = m_sel();
    f = -1;
    for (int i = 0; i < N; i++) if (!m_v[i] && f < 0) f = i;
    if (reset || mispredicted) begin
      for (int i = 0; i < N; i++) begin
        m_v[i] = 1'b0; m_qj[i] = '0; m_qk[i] = '0; m_vj[i] = '0; m_vk[i] = '0;
        m_rob[i] = '0; m_op[i] = '0; m_br[i] = '0; m_ld[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_v[i]) begin
          h = m_snoop(m_qj[i]);
          if (h[XLEN]) begin m_qj[i] = '0; m_vj[i] = h[XLEN-1:0]; end
          h = m_snoop(m_qk[i]);
          if (h[XLEN]) begin m_qk[i] = '0; m_vk[i] = h[XLEN-1:0]; end
        end
      end
      if (s >= 0 && issue_ready) m_v[s] = 1'b0;
      if (alloc_valid && f >= 0) begin
        a = alloc_data;
        m_v[f] = 1'b1;
        m_seq[f] = seq_ctr++;
        m_qj[f] = a[0 +: ROB_W];
        m_qk[f] = a[ROB_W +: ROB_W];
        m_vj[f] = a[2*ROB_W +: XLEN];
        m_vk[f] = a[2*ROB_W+XLEN +: XLEN];
        m_rob[f] = a[2*ROB_W+2*XLEN +: ROB_W];
        m_op[f] = a[3*ROB_W+2*XLEN +: 4];
        m_br[f] = a[3*ROB_W+2*XLEN+4 +: 3];
        m_ld[f] = a[RS_W-1];
        h = m_snoop(m_qj[f]);
        if (h[XLEN]) begin m_qj[f] = '0; m_vj[f] = h[XLEN-1:0]; end
        h = m_snoop(m_qk[f]);
        if (h[XLEN]) begin m_qk[f] = '0; m_vk[f] = h[XLEN-1:0]; end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    m_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mispredicted = 1'b0; alloc_valid = 1'b0; issue_ready = 1'b0;
    alloc_data = '0; CDB_in = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc(input logic [RS_W-1:0] d);
    alloc_valid = 1'b1; alloc_data = d;
    tick();
    alloc_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    reset = 1'b1; alloc_valid = 1'b1; alloc_data = mk_rs(0, 0, 1, 2, 5);
    tick();
    reset = 1'b0; alloc_valid = 1'b0;
    #1;
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
    n_checks++; if (free_count !== CNT_W'(N)) begin n_fail++; $display("FAIL reset_free_count: got %0d expected %0d", free_count, N); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
    n_checks++; if (issue_data !== '0) begin n_fail++; $display("FAIL reset_issue_data: got %h expected 0", issue_data); end
  endtask

  task automatic test_basic();
    do_reset();
    alloc(mk_rs(0, 0, 5, 7, 3));
    #1;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", issue_valid); end
    n_checks++; if (issue_data !== mk_out(5, 7, 3)) begin n_fail++; $display("FAIL basic_data: got %h expected %h", issue_data, mk_out(5, 7, 3)); end
    n_checks++; if (free_count !== CNT_W'(3)) begin n_fail++; $display("FAIL basic_free_busy: got %0d expected 3", free_count); end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    #1;
    n_checks++; if (free_count !== CNT_W'(4)) begin n_fail++; $display("FAIL basic_free_after: got %0d expected 4", free_count); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid: got %b expected 0", issue_valid); end
  endtask

  task automatic test_wakeup();
    do_reset();
    alloc(mk_rs(6, 0, 0, 1, 2));
    CDB_in = {mk_cdb(0, 0, 0), mk_cdb(6, 32'hAB, 1'b1)};
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_pending: got %b expected 0", issue_valid); end
    tick();
    CDB_in = {mk_cdb(0, 0, 0), mk_cdb(6, 32'hCD, 1'b0)};
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_load_step1_or_same_cycle: got %b expected 0", issue_valid); end
    tick();
    CDB_in = '0;
    #1;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL wakeup_valid: got %b expected 1", issue_valid); end
    n_checks++; if (issue_data !== mk_out(32'hCD, 1, 2)) begin n_fail++; $display("FAIL wakeup_data: got %h expected %h", issue_data, mk_out(32'hCD, 1, 2)); end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    CDB_in = {mk_cdb(9, 32'h22, 1'b0), mk_cdb(2, 32'h11, 1'b0)};
    alloc(mk_rs(2, 9, 0, 0, 7));
    CDB_in = '0;
    #1;
    n_checks++; if (issue_data !== mk_out(32'h11, 32'h22, 7)) begin n_fail++; $display("FAIL bypass_data: got %h expected %h", issue_data, mk_out(32'h11, 32'h22, 7)); end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    alloc(mk_rs(3, 0, 0, 5, 6));
    CDB_in = {mk_cdb(3, 32'h44, 1'b0), mk_cdb(3, 32'h33, 1'b0)};
    tick();
    CDB_in = '0;
    #1;
    n_checks++; if (issue_data !== mk_out(32'h33, 5, 6)) begin n_fail++; $display("FAIL lowest_port_wins: got %h expected %h", issue_data, mk_out(32'h33, 5, 6)); end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic test_full_flush();
    do_reset();
    for (int i = 0; i < N; i++) alloc(mk_rs(ROB_W'(10 + i), 0, 0, 0, ROB_W'(1 + i)));
    alloc_valid = 1'b1; alloc_data = mk_rs(0, 0, 1, 1, 7);
    #1;
    n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_alloc_ready: got %b expected 0", alloc_ready); end
    n_checks++; if (free_count !== CNT_W'(0)) begin n_fail++; $display("FAIL full_free_count: got %0d expected 0", free_count); end
    tick();
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_ignored_alloc: got %b expected 0", issue_valid); end
    mispredicted = 1'b1;
    tick();
    mispredicted = 1'b0; alloc_valid = 1'b0;
    #1;
    n_checks++; if (free_count !== CNT_W'(4)) begin n_fail++; $display("FAIL flush_free_count: got %0d expected 4", free_count); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_issue_valid: got %b expected 0", issue_valid); end
    CDB_in = {mk_cdb(11, 1, 1'b0), mk_cdb(10, 1, 1'b0)};
    tick();
    CDB_in = {mk_cdb(13, 1, 1'b0), mk_cdb(12, 1, 1'b0)};
    tick();
    CDB_in = '0;
    #1;
    n_checks++; if (issue_valid !== 1'b0 || free_count !== CNT_W'(4)) begin
      n_fail++; $display("FAIL flush_no_survivor: got valid=%b free=%0d expected valid=0 free=4", issue_valid, free_count);
    end
  endtask

  task automatic test_age_order();
    do_reset();
    exp_q.delete();
`ifdef RS_AGE_ORDER_EN
    exp_q.push_back(ROB_W'(3)); exp_q.push_back(ROB_W'(2)); exp_q.push_back(ROB_W'(4));
`else
    exp_q.push_back(ROB_W'(4)); exp_q.push_back(ROB_W'(2)); exp_q.push_back(ROB_W'(3));
`endif
    alloc(mk_rs(4, 0, 0, 0, 1));
    alloc(mk_rs(5, 0, 0, 0, 2));
    alloc(mk_rs(6, 0, 0, 0, 3));
    CDB_in = {mk_cdb(0, 0, 0), mk_cdb(4, 32'h40, 1'b0)};
    tick();
    CDB_in = '0; issue_ready = 1'b1;
    #1;
    n_checks++; if (issue_data !== mk_out(32'h40, 0, 1)) begin n_fail++; $display("FAIL age_issue_a: got %h expected %h", issue_data, mk_out(32'h40, 0, 1)); end
    tick();
    issue_ready = 1'b0;
    alloc(mk_rs(0, 0, 8, 9, 4));
    CDB_in = {mk_cdb(0, 0, 0), mk_cdb(6, 32'h60, 1'b0)};
    tick();
    CDB_in = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (issue_valid !== 1'b1 || issue_data[2*XLEN +: ROB_W] !== exp_q[0]) begin
        n_fail++; $display("FAIL age_hold: got valid=%b rob=%0d expected rob=%0d", issue_valid, issue_data[2*XLEN +: ROB_W], exp_q[0]);
      end
      n_checks++; if (issue_data !== m_out()) begin n_fail++; $display("FAIL age_hold_model: got %h expected %h", issue_data, m_out()); end
      tick();
    end
    issue_ready = 1'b1;
    #1;
    n_checks++; if (!issue_valid || issue_data[2*XLEN +: ROB_W] !== exp_q.pop_front()) begin
      n_fail++; $display("FAIL age_first: got valid=%b rob=%0d", issue_valid, issue_data[2*XLEN +: ROB_W]);
    end
    tick();
    issue_ready = 1'b0;
    CDB_in = {mk_cdb(0, 0, 0), mk_cdb(5, 32'h50, 1'b0)};
    tick();
    CDB_in = '0; issue_ready = 1'b1;
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      #1;
      if (issue_valid) begin
        n_checks++; if (issue_data[2*XLEN +: ROB_W] !== exp_q[0]) begin
          n_fail++; $display("FAIL age_order: got rob=%0d expected rob=%0d", issue_data[2*XLEN +: ROB_W], exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
    end
    issue_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL age_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    alloc(mk_rs(0, 0, 32'h1111, 32'h2222, 9));
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (issue_valid !== 1'b1 || issue_data !== mk_out(32'h1111, 32'h2222, 9) || free_count !== CNT_W'(3)) begin
        n_fail++; $display("FAIL backpressure_hold: got valid=%b data=%h free=%0d expected valid=1 free=3", issue_valid, issue_data, free_count);
      end
      tick();
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    #1;
    n_checks++; if (free_count !== CNT_W'(4) || issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release: got free=%0d valid=%b expected free=4 valid=0", free_count, issue_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      mispredicted = ($urandom_range(0, 39) == 0);
      alloc_valid = ($urandom_range(0, 3) != 0);
      alloc_data = RS_W'({$urandom, $urandom, $urandom});
      alloc_data[0 +: ROB_W] = ROB_W'($urandom_range(0, 7));
      alloc_data[ROB_W +: ROB_W] = ROB_W'($urandom_range(0, 7));
      for (int c = 0; c < NC; c++)
        CDB_in[c*CDB_W +: CDB_W] = mk_cdb(ROB_W'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0));
      issue_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_checks++; if (alloc_ready !== (m_free() > 0)) begin n_fail++; $display("FAIL rand_alloc_ready cyc %0d: got %b", cyc, alloc_ready); end
      n_checks++; if (free_count !== CNT_W'(m_free())) begin n_fail++; $display("FAIL rand_free_count cyc %0d: got %0d expected %0d", cyc, free_count, m_free()); end
      n_checks++; if (issue_valid !== (m_sel() >= 0)) begin n_fail++; $display("FAIL rand_issue_valid cyc %0d: got %b", cyc, issue_valid); end
      n_checks++; if (issue_data !== m_out()) begin n_fail++; $display("FAIL rand_issue_data cyc %0d: got %h expected %h", cyc, issue_data, m_out()); end
      tick();
    end
    mispredicted = 1'b0; alloc_valid = 1'b0; issue_ready = 1'b0; CDB_in = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full_flush();
    test_age_order();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_bank.md
# rs_bank

Parametrised reservation-station bank for one functional-unit class: it holds `NUM_ENTRIES` in-flight instructions between issue and execute. Operands are captured from `NUM_CDB` common data buses. One operand-ready entry per cycle goes to the FU over a valid/ready handshake, and an entry's slot is freed on that handshake. It sits between the issue/dispatch stage (producer) and one FU (consumer), and is flushed on misprediction.

## Interface
- `NUM_ENTRIES`, 4: entry count, ≥2.
- `NUM_CDB`, 1: number of CDB ports snooped, ≥1.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `mispredicted` in 1: synchronous flush of all entries.
- `alloc_valid` in 1: dispatch offers `alloc_data`.
- `alloc_ready` out 1: at least one free entry.
- `alloc_data` in `rs_data_t`: new entry. `Q_j`/`Q_k` = 0 means the operand is in `V_j`/`V_k`.
- `CDB_in` in `CDB_packet_t [NUM_CDB]`: broadcast results.
- `issue_valid` out 1: a ready entry is presented.
- `issue_ready` in 1: FU accepts.
- `issue_data` out `rs_out_t`: selected entry. `valid_operands` = `issue_valid`.
- `free_count` out `$clog2(NUM_ENTRIES)+1`: number of free entries.

## Operation
- Per-entry state: `v` (occupied), `Q_j`, `Q_k`, `V_j`, `V_k`, `ROB_entry`, `ALU_op`, `branch_type`, `load`.
- Entry ready: `v` set, `Q_j == 0` and `Q_k == 0`.

**Allocate** (`alloc_valid & alloc_ready`)
- Writes the lowest-index free entry and sets its `v`.
- Same-cycle CDB bypass: if a CDB port matches `alloc_data.Q_j` or `Q_k`, the stored operand takes that port's result and its tag is stored as 0.

**Wakeup**
- Each cycle, for each occupied entry and each operand with nonzero tag: if a CDB port `c` has `dest_ROB_entry == tag` and `~load_step1`, the operand takes `result` and its tag clears to 0.
- Multiple matching ports: the lowest `c` wins.

**Select**
- Among ready entries, the oldest is chosen (see Configuration).
- `issue_data` is combinational from the selected entry, and is all-zero when `issue_valid` = 0.

**Issue**
- On `issue_valid & issue_ready`, the selected entry's `v` clears at the clock edge.
- With `issue_ready` = 0, the selection may change only toward an older entry becoming ready. The presented entry is never removed without a handshake.

**Age matrix**
- `NUM_ENTRIES²` bits; `age[i][j]` = 1 means i is older than j.
- On allocating entry k, k is marked younger than every entry occupied at that edge.

**Flush**
- `reset` or `mispredicted` clears all `v`, all tags and all payloads.
- Flush has priority over a same-cycle alloc, issue and wakeup; the allocated instruction is dropped.

## Timing
- Reset values:
  - `alloc_ready` = 1, `free_count` = `NUM_ENTRIES`.
  - `issue_valid` = 0, `issue_data` = 0.
- Allocation-to-issue latency:
  - Operands ready or bypassed at allocation: an entry allocated at edge t can be presented in the cycle after t.
  - A CDB wakeup at edge t makes the entry issuable in the cycle after t. There is no same-cycle CDB-to-issue path.
- `alloc_ready` and `free_count` depend on registered state only. They do not depend on `issue_ready`.
- A slot freed by an issue at edge t is allocatable after t.
- Simultaneous alloc and issue are both performed. The freed and allocated entries are always different, because the allocation target is a free entry.
- Full (`free_count` = 0): `alloc_ready` = 0 and `alloc_valid` is ignored.
- Empty: `issue_valid` = 0.
- A CDB result for a tag not held by any entry has no effect.
- Tag 0 never matches.

## Configuration
- `RS_AGE_ORDER_EN` defined:
  - Age matrix built as above.
  - Select picks the oldest ready entry.
- Undefined:
  - No age matrix is instantiated.
  - Select picks the lowest-index ready entry.
  - All other behaviour is identical.

## Test plan
- **Basic issue:** after reset, allocate {Q_j=0, Q_k=0, V_j=5, V_k=7, ROB=3}. Expect `issue_valid`=1 next cycle with rs1=5, rs2=7, ROB_entry=3. With `issue_ready`=1, the slot frees and `free_count` returns to 4.
- **Wakeup:** allocate {Q_j=6, Q_k=0}. Drive CDB {dest=6, result=0xAB, load_step1=1}: no change. Then drive {dest=6, result=0xCD, load_step1=0}: expect `issue_valid` in the next cycle with rs1=0xCD.
- **Alloc bypass / multi-CDB (`NUM_CDB`=2):** allocate {Q_j=2, Q_k=9} while CDB0 dest=2 (result 0x11) and CDB1 dest=9 (result 0x22). Expect an issue the following cycle with rs1=0x11, rs2=0x22.
- **Full and flush:** fill 4 entries with unresolved tags. Expect `alloc_ready`=0, and a fifth `alloc_valid` is ignored. Assert `mispredicted` together with an `alloc_valid`. Expect `free_count`=4, `issue_valid`=0, and no entry survives.
- **Age ordering (`RS_AGE_ORDER_EN`):**
  - Allocate A (tag 4) into entry 0, B (tag 5) into entry 1, C (tag 6) into entry 2, then issue A so that entry 0 frees.
  - Allocate D (operands ready) into entry 0.
  - Broadcast tag 6, then tag 5.
  - With `issue_ready`=0, expect C presented. Hold it until the handshake; B follows; D is presented last despite having index 0.
  - Without the macro, D is presented first.
- **Backpressure:** with `issue_ready`=0 for 5 cycles on a ready entry, `issue_data` stays stable. Only the handshake edge frees the entry.
